route_cap_table: RTL and testbench
==================================

# route_cap_table

Parametrised route-capability table for the DTU send gate. It holds one CAP_W-bit route capability per destination, written by the host and revoked or flushed on command. It answers registered lookups by upper-layer port with a valid/ready response that carries a hit flag. It sits between the host capability-write path and the send datapath, which consumes `route_out`.

## Interface

- Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `N_DESTS`, 4: number of table entries, 1..256.
- `CAP_W`, 14: capability and route width, at least ID_W+1.
- `ID_W`, `(N_DESTS>1)?$clog2(N_DESTS):1`: index width.
- `LEASE_W`, 16: lease counter width. Used only with the lease macro.
- `LEASE_CYCLES`, 1000: lease reload value, in the range 1..2^LEASE_W-1.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `cap_wr_valid`  in  1  capability write/revoke request.
- `cap_wr_ready`  out  1  write accepted when both valid and ready are high.
- `cap_wr_data`  in  CAP_W  capability. Entry index = `cap_wr_data[ID_W-1:0]`.
- `cap_wr_revoke`  in  1  1 = invalidate the indexed entry; the data is ignored.
- `lookup_valid`  in  1  lookup request.
- `lookup_ready`  out  1  lookup accept.
- `lookup_port`  in  ID_W  entry to read.
- `route_valid`  out  1  response valid.
- `route_ready`  in  1  response accept.
- `route_out`  out  CAP_W  stored capability; 0 on a miss.
- `route_hit`  out  1  entry was valid and in range.
- `flush`  in  1  single-cycle pulse; invalidates all entries.
- `busy`  out  1  high while in the FLUSH state.
- `wr_drop_cnt`  out  16  saturating count of out-of-range writes.

## Operation

- Storage: `valid[N_DESTS]` and `cap[N_DESTS][CAP_W]`. Reset clears `valid` asynchronously; `cap` contents are don't-care after reset.
- Write, on accept:
  - index < N_DESTS and revoke=0: `cap` ← data, `valid` ← 1.
  - index < N_DESTS and revoke=1: `valid` ← 0.
  - index ≥ N_DESTS: no table change; `wr_drop_cnt` increments, saturating at 0xFFFF.
- FSM states: IDLE, RESP, FLUSH.
  - IDLE → RESP on a lookup accept.
  - RESP → IDLE on `route_ready` with no new accept. RESP stays in RESP on `route_ready` combined with a new accept.
  - IDLE → FLUSH when a flush is pending. From RESP, the flush is taken after the response handshake completes; no new lookup is accepted in that cycle.
  - FLUSH → IDLE after N_DESTS cycles.
- `lookup_ready` = (IDLE or (RESP and `route_ready`)) and no flush pending.
- `cap_wr_ready` = not FLUSH and `aresetn` high.
- Lookup response is snapshotted at accept: `route_hit` = valid[port] and port < N_DESTS; `route_out` = `route_hit` ? cap[port] : 0.
- A write and a lookup to the same index in the same cycle: the lookup returns the pre-write value.
- Flush:
  - The pulse sets a pending flag. A flush arriving while pending or in FLUSH is absorbed; there is no restart.
  - FLUSH clears entry k on its k-th cycle, k = 0..N_DESTS-1.
  - Writes and lookups are stalled throughout FLUSH.

## Timing

- Reset values: `route_valid`=0, `route_out`=0, `route_hit`=0, `busy`=0, `wr_drop_cnt`=0, `lookup_ready`=1 once reset is released, `cap_wr_ready`=0 while in reset.
- Lookup latency: accept at edge N gives `route_valid` and data registered at N+1.
- Response is held stable while `route_valid` is high and `route_ready` is low.
- Throughput: 1 lookup per cycle when `route_ready` is held high.
- Write visibility: a lookup accepted in the cycle after the write sees the new value.
- Flush duration: FLUSH lasts exactly N_DESTS cycles; `busy` is high for those cycles.
- Reset asserted mid-operation: everything returns to reset values immediately and the FSM goes to IDLE.

## Configuration

- `ROUTE_CAP_LEASE_EN`, defined:
  - Each entry has a LEASE_W-bit counter, loaded with LEASE_CYCLES on every non-revoke write, including rewrites of a valid entry.
  - The counter decrements each cycle while the entry is valid. When it is at 1 the entry clears, so validity lasts exactly LEASE_CYCLES cycles.
  - A write in the expiry cycle wins: the entry stays valid and the counter reloads.
  - Revoke and flush also zero the counter.
- `ROUTE_CAP_LEASE_EN`, undefined: no counters. Entries persist until revoke, flush or reset. `LEASE_W` and `LEASE_CYCLES` are ignored.

## Test plan

- Write 0x0A5 (index 1), then look up port 1 with `route_ready`=1 → next cycle `route_valid`=1, `route_hit`=1, `route_out`=0x0A5.
- Write 0x0A5 then revoke index 1; look up port 1 → `route_hit`=0, `route_out`=0.
- N_DESTS=3: write 0x003 (index 3) → table unchanged, `wr_drop_cnt`=1; look up port 3 → miss.
- Fill all 4 entries, pulse `flush` → `busy` high for exactly 4 cycles, `lookup_ready`=0 meanwhile; every lookup afterwards misses.
- Hold `route_ready`=0 for 5 cycles during a response → `route_out` stable and no new accept; then 4 back-to-back lookups complete in 4 cycles.
- With `ROUTE_CAP_LEASE_EN` and LEASE_CYCLES=8: write index 2 → a lookup accepted 7 cycles later hits; one accepted 8 cycles later misses.

Source files
------------

// File: rtl/route_cap_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | route_cap_table: per-destination route capability table with registered  |
// | lookup response and sequenced flush. Lease expiry: ROUTE_CAP_LEASE_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module route_cap_table #(
  parameter int N_DESTS      = 4,
  parameter int CAP_W        = 14,
  parameter int ID_W         = (N_DESTS > 1) ? $clog2(N_DESTS) : 1,
  parameter int LEASE_W      = 16,
  parameter int LEASE_CYCLES = 1000
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cap_wr_valid,
  output logic             cap_wr_ready,
  input  logic [CAP_W-1:0] cap_wr_data,
  input  logic             cap_wr_revoke,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [ID_W-1:0]  lookup_port,
  output logic             route_valid,
  input  logic             route_ready,
  output logic [CAP_W-1:0] route_out,
  output logic             route_hit,
  input  logic             flush,
  output logic             busy,
  output logic [15:0]      wr_drop_cnt
);

  localparam bit PARAMS_OK = (CAP_W >= ID_W + 1) && (N_DESTS >= 1) && (N_DESTS <= 256) &&
                             (LEASE_CYCLES >= 1) && (LEASE_W >= 1) &&
                             (longint'(LEASE_CYCLES) < (longint'(1) << LEASE_W));

  if (!PARAMS_OK) begin : g_param_check
    $error("route_cap_table: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic             flush_pend;
  logic [ID_W-1:0]  flush_idx;
  logic [N_DESTS-1:0] live;
  logic [CAP_W-1:0] cap_arr [N_DESTS];

  logic [ID_W-1:0]  wr_idx;
  logic             wr_fire, wr_in_range, wr_set, wr_clr;
  logic             lk_fire, lk_hit;
  logic [CAP_W-1:0] lk_cap;

  assign wr_idx       = cap_wr_data[ID_W-1:0];
  assign cap_wr_ready = (state != FLUSH) && aresetn;
  assign lookup_ready = ((state == IDLE) || ((state == RESP) && route_ready)) && !flush_pend;
  assign route_valid  = (state == RESP);
  assign busy         = (state == FLUSH);

  assign wr_fire     = cap_wr_valid && cap_wr_ready;
  assign wr_in_range = ({1'b0, wr_idx} < (ID_W+1)'(N_DESTS));
  assign wr_set      = wr_fire && wr_in_range && !cap_wr_revoke;
  assign wr_clr      = wr_fire && wr_in_range && cap_wr_revoke;
  assign lk_fire     = lookup_valid && lookup_ready;

  for (genvar k = 0; k < N_DESTS; k++) begin : g_entry
    logic             v;
    logic [CAP_W-1:0] c;
    logic             sel_wr, flush_clr;

    assign sel_wr    = (wr_idx == ID_W'(k));
    assign flush_clr = (state == FLUSH) && (flush_idx == ID_W'(k));
    assign cap_arr[k] = c;

`ifdef ROUTE_CAP_LEASE_EN
    logic [LEASE_W-1:0] lease;
    // An entry whose counter sits at 1 is in its expiry cycle and no longer answers hits.
    assign live[k] = v && (lease != LEASE_W'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        v     <= 1'b0;
        lease <= '0;
      end else if (wr_set && sel_wr) begin
        v     <= 1'b1;
        lease <= LEASE_W'(LEASE_CYCLES);
      end else if ((wr_clr && sel_wr) || flush_clr || (v && (lease == LEASE_W'(1)))) begin
        v     <= 1'b0;
        lease <= '0;
      end else if (v) begin
        lease <= lease - LEASE_W'(1);
      end
    end
`else
    assign live[k] = v;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
        v <= 1'b0;
      else if (wr_set && sel_wr)
        v <= 1'b1;
      else if ((wr_clr && sel_wr) || flush_clr)
        v <= 1'b0;
    end
`endif

    always_ff @(posedge aclk) begin
      if (wr_set && sel_wr)
        c <= cap_wr_data;
    end
  end

  // Read from pre-write state so a same-cycle write is not visible to the lookup.
  always_comb begin
    lk_hit = 1'b0;
    lk_cap = '0;
    for (int k = 0; k < N_DESTS; k++) begin
      if (lookup_port == ID_W'(k)) begin
        lk_hit = live[k];
        lk_cap = cap_arr[k];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      flush_idx  <= '0;
      route_out  <= '0;
      route_hit  <= 1'b0;
    end else begin
      if (flush && (state != FLUSH))
        flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (flush_pend) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
            flush_idx  <= '0;
          end else if (lk_fire) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (route_ready) begin
            if (lk_fire) begin
              state <= RESP;
            end else if (flush_pend) begin
              state      <= FLUSH;
              flush_pend <= 1'b0;
              flush_idx  <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          flush_idx <= flush_idx + ID_W'(1);
          if (flush_idx == ID_W'(N_DESTS - 1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (lk_fire) begin
        route_hit <= lk_hit;
        route_out <= lk_hit ? lk_cap : '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      wr_drop_cnt <= '0;
    else if (wr_fire && !wr_in_range && (wr_drop_cnt != 16'hFFFF))
      wr_drop_cnt <= wr_drop_cnt + 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_route_cap_table.sv
`default_nettype none
// tb_route_cap_table: directed stimulus checked every cycle against a
// table-level behavioural model, plus literal expectations from the test plan.
module tb_route_cap_table;

  localparam int N     = 4;
  localparam int CW    = 14;
  localparam int IW    = 2;
  localparam int LEASE = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic          cap_wr_valid, cap_wr_revoke, lookup_valid, route_ready, flush;
  logic [CW-1:0] cap_wr_data;
  logic [IW-1:0] lookup_port;
  logic          cap_wr_ready, lookup_ready, route_valid, route_hit, busy;
  logic [CW-1:0] route_out;
  logic [15:0]   wr_drop_cnt;

  route_cap_table #(.N_DESTS(N), .CAP_W(CW), .ID_W(IW), .LEASE_W(16), .LEASE_CYCLES(LEASE)) dut (
    .aclk(clk), .aresetn(rst_n),
    .cap_wr_valid(cap_wr_valid), .cap_wr_ready(cap_wr_ready), .cap_wr_data(cap_wr_data),
    .cap_wr_revoke(cap_wr_revoke), .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_port(lookup_port), .route_valid(route_valid), .route_ready(route_ready),
    .route_out(route_out), .route_hit(route_hit), .flush(flush), .busy(busy),
    .wr_drop_cnt(wr_drop_cnt)
  );

  // Three-entry table for the out-of-range index case.
  logic          d3_wv, d3_lv;
  logic [CW-1:0] d3_wd;
  logic [IW-1:0] d3_port;
  logic          d3_wrdy, d3_lrdy, d3_rv, d3_hit, d3_busy;
  logic [CW-1:0] d3_out;
  logic [15:0]   d3_drop;

  route_cap_table #(.N_DESTS(3), .CAP_W(CW), .ID_W(IW), .LEASE_W(16), .LEASE_CYCLES(LEASE)) dut3 (
    .aclk(clk), .aresetn(rst_n),
    .cap_wr_valid(d3_wv), .cap_wr_ready(d3_wrdy), .cap_wr_data(d3_wd),
    .cap_wr_revoke(1'b0), .lookup_valid(d3_lv), .lookup_ready(d3_lrdy),
    .lookup_port(d3_port), .route_valid(d3_rv), .route_ready(1'b1),
    .route_out(d3_out), .route_hit(d3_hit), .flush(1'b0), .busy(d3_busy),
    .wr_drop_cnt(d3_drop)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid [N];
  logic [CW-1:0] m_cap   [N];
  int            m_wcyc  [N];
  int            cyc;
  logic          m_out_v, m_hit, m_pend;
  logic [CW-1:0] m_route;
  int            m_fleft, m_drop;

  function automatic logic m_live(input int k);
`ifdef ROUTE_CAP_LEASE_EN
    return m_valid[k] && ((cyc - m_wcyc[k]) < LEASE);
`else
    return m_valid[k];
`endif
  endfunction

  function automatic logic m_lready();
    return (!m_out_v || route_ready) && !m_pend && (m_fleft == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_valid[k] <= 1'b0;
      m_out_v <= 1'b0; m_hit <= 1'b0; m_route <= '0;
      m_pend <= 1'b0; m_fleft <= 0; m_drop <= 0; cyc <= 0;
    end else begin : step
      logic acc;
      int   idx, p;
      cyc <= cyc + 1;
      acc = lookup_valid && m_lready();
      if (acc) begin
        p = int'(lookup_port);
        m_out_v <= 1'b1;
        m_hit   <= m_live(p);
        m_route <= m_live(p) ? m_cap[p] : '0;
      end else if (route_ready) begin
        m_out_v <= 1'b0;
      end
      if (cap_wr_valid && (m_fleft == 0)) begin
        idx = int'(cap_wr_data[IW-1:0]);
        if (idx >= N) begin
          if (m_drop < 65535) m_drop <= m_drop + 1;
        end else if (cap_wr_revoke) begin
          m_valid[idx] <= 1'b0;
        end else begin
          m_valid[idx] <= 1'b1;
          m_cap[idx]   <= cap_wr_data;
          m_wcyc[idx]  <= cyc;
        end
      end
      if (m_fleft > 0) begin
        m_valid[N - m_fleft] <= 1'b0;
        m_fleft <= m_fleft - 1;
      end else if (m_pend && (!m_out_v || route_ready)) begin
        m_fleft <= N;
        m_pend  <= 1'b0;
      end else if (flush) begin
        m_pend <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("lookup_ready", lookup_ready, m_lready());
      chk("cap_wr_ready", cap_wr_ready, m_fleft == 0);
      chk("busy", busy, m_fleft > 0);
      chk("route_valid", route_valid, m_out_v);
      if (m_out_v) begin
        chk("route_out", route_out, m_route);
        chk("route_hit", route_hit, m_hit);
      end
      chk("wr_drop_cnt", wr_drop_cnt, m_drop);
    end
  end

  // ---------------- stimulus ----------------
  task automatic write(input logic [CW-1:0] d, input logic rv);
    @(negedge clk);
    cap_wr_valid = 1'b1; cap_wr_data = d; cap_wr_revoke = rv;
    @(negedge clk);
    cap_wr_valid = 1'b0; cap_wr_revoke = 1'b0;
  endtask

  task automatic lookup(input logic [IW-1:0] p);
    @(negedge clk);
    lookup_valid = 1'b1; lookup_port = p;
    @(negedge clk);
    lookup_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [CW-1:0] exp;
    cap_wr_valid = 0; cap_wr_revoke = 0; cap_wr_data = '0; lookup_valid = 0;
    lookup_port = '0; flush = 0; route_ready = 1;
    d3_wv = 0; d3_wd = '0; d3_lv = 0; d3_port = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_route_valid", route_valid, 0);
    chk("rst_route_out", route_out, 0);
    chk("rst_route_hit", route_hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", wr_drop_cnt, 0);
    chk("rst_wr_ready", cap_wr_ready, 0);
    chk("rst_d3_state", {d3_rv, d3_hit, d3_busy, d3_wrdy}, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk("post_rst_lookup_ready", lookup_ready, 1);
    chk("post_rst_wr_ready", cap_wr_ready, 1);

    // Write then lookup
    write(14'h0A5, 1'b0);
    lookup(2'd1);
    chk("hit_valid", route_valid, 1);
    chk("hit_flag", route_hit, 1);
    chk("hit_data", route_out, 14'h0A5);

    // Same-cycle write and lookup return the old value
    @(negedge clk);
    cap_wr_valid = 1; cap_wr_data = 14'h0A9; lookup_valid = 1; lookup_port = 2'd1;
    @(negedge clk);
    cap_wr_valid = 0; lookup_valid = 0;
    chk("same_cycle_old", route_out, 14'h0A5);
    lookup(2'd1);
    chk("next_cycle_new", route_out, 14'h0A9);

    // Revoke
    write(14'h001, 1'b1);
    lookup(2'd1);
    chk("revoke_hit", route_hit, 0);
    chk("revoke_data", route_out, 0);

    // Out-of-range write on the three-entry table
    @(negedge clk); d3_wv = 1; d3_wd = 14'h003;
    @(negedge clk); d3_wv = 0;
    chk("d3_drop", d3_drop, 1);
    @(negedge clk); d3_lv = 1; d3_port = 2'd3;
    @(negedge clk); d3_lv = 0;
    chk("d3_oor_valid", d3_rv, 1);
    chk("d3_oor_hit", d3_hit, 0);
    chk("d3_oor_data", d3_out, 0);
    @(negedge clk); d3_wv = 1; d3_wd = 14'h002;
    @(negedge clk); d3_wv = 0; d3_lv = 1; d3_port = 2'd2;
    @(negedge clk); d3_lv = 0;
    chk("d3_in_hit", d3_hit, 1);
    chk("d3_in_data", d3_out, 14'h002);
    chk("d3_drop_hold", d3_drop, 1);
    chk("d3_ready", {d3_lrdy, d3_wrdy, d3_busy}, 3'b110);

    // Fill, then stall the response for 5 cycles
    for (int k = 0; k < N; k++) write(14'h1230 | CW'(k), 1'b0);
    @(negedge clk); route_ready = 0; lookup_valid = 1; lookup_port = 2'd1;
    @(negedge clk); lookup_port = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", route_valid, 1);
      chk("stall_ready", lookup_ready, 0);
      chk("stall_data", route_out, 14'h1231);
      @(negedge clk);
    end
    route_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = 14'h1230 | CW'((2 + i) % 4);
      chk("b2b_valid", route_valid, 1);
      chk("b2b_data", route_out, exp);
      lookup_port = IW'((3 + i) % 4);
    end
    lookup_valid = 0;
    @(negedge clk);

    // Flush, with a second pulse absorbed mid-flush
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    chk("flush_pend_ready", lookup_ready, 0);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      flush = (i == 0);
      if (busy) begin
        nb++;
        chk("flush_lookup_ready", lookup_ready, 0);
      end
    end
    flush = 0;
    chk("busy_cycles", nb, 4);
    for (int k = 0; k < N; k++) begin
      lookup(IW'(k));
      chk("post_flush_hit", route_hit, 0);
    end

    // Lease boundary: accept 7 cycles after the write hits, 8 cycles after misses
    write(14'h0A6, 1'b0);
    repeat (5) @(negedge clk);
    lookup(2'd2);
`ifdef ROUTE_CAP_LEASE_EN
    chk("lease_7_hit", route_hit, 1);
`endif
    write(14'h0A6, 1'b0);
    repeat (6) @(negedge clk);
    lookup(2'd2);
`ifdef ROUTE_CAP_LEASE_EN
    chk("lease_8_miss", route_hit, 0);
`endif

    // Asynchronous reset in the middle of a response
    write(14'h0A5, 1'b0);
    @(negedge clk); lookup_valid = 1; lookup_port = 2'd1;
    @(negedge clk); lookup_valid = 0;
    chk("pre_reset_valid", route_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", route_valid, 0);
    chk("mid_rst_out", route_out, 0);
    chk("mid_rst_wr_ready", cap_wr_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    lookup(2'd1);
    chk("after_rst_miss", route_hit, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
